// File: rtl/sprite_blitter.sv
// XOR sprite blitter into a 1-bpp framebuffer; 5 cycles per aligned row, 8 per straddling row, done 1 cycle after last write.
// No backpressure; start is only honoured in IDLE. Define BLIT_WRAP_EN for toroidal wrap, otherwise off-screen bits are clipped.
module sprite_blitter #(
  parameter int DISP_W   = 64,
  parameter int DISP_H   = 32,
  parameter int MAX_ROWS = 16,
  localparam int AW      = $clog2(DISP_W * DISP_H / 8)
) (
  input  logic          clk_in,
  input  logic          rst_n,
  input  logic          start,
  input  logic [11:0]   sprite_addr,
  input  logic [7:0]    x,
  input  logic [7:0]    y,
  input  logic [4:0]    rows,
  output logic [11:0]   mem_rd_addr,
  input  logic [7:0]    mem_rd_data,
  output logic [AW-1:0] vram_addr,
  input  logic [7:0]    vram_rd_data,
  output logic [7:0]    vram_wr_data,
  output logic          vram_we,
  output logic          busy,
  output logic          done,
  output logic          collision
);

  localparam logic [3:0] IDLE       = 4'd0;
  localparam logic [3:0] FETCH      = 4'd1;
  localparam logic [3:0] FETCH_WAIT = 4'd2;
  localparam logic [3:0] RD0        = 4'd3;
  localparam logic [3:0] RD0_WAIT   = 4'd4;
  localparam logic [3:0] WR0        = 4'd5;
  localparam logic [3:0] RD1        = 4'd6;
  localparam logic [3:0] RD1_WAIT   = 4'd7;
  localparam logic [3:0] WR1        = 4'd8;
  localparam logic [3:0] NEXT       = 4'd9;
  localparam logic [3:0] DONE       = 4'd10;

  localparam int         BPL  = DISP_W / 8;
  localparam logic [4:0] MAXR = 5'(MAX_ROWS);
`ifdef BLIT_WRAP_EN
  localparam bit WRAP = 1'b1;
`else
  localparam bit WRAP = 1'b0;
`endif

  logic [3:0]    state_q, state_d;
  logic [11:0]   base_q, base_d;
  logic [7:0]    x_q, x_d, y_q, y_d, spr_q, spr_d, wr_dat_q, wr_dat_d;
  logic [4:0]    rows_q, rows_d, r_q, r_d;
  logic [11:0]   mem_addr_q, mem_addr_d;
  logic [AW-1:0] vram_addr_q, vram_addr_d;
  logic          we_q, we_d, coll_q, coll_d;

  logic [8:0]  line9, line_w, line_nx, col0, col1_raw, col1;
  logic [4:0]  r_nx, rows_sat;
  logic [15:0] shifted;
  logic [7:0]  mask0, mask1;
  logic        has_b1, last_row, adv;

  function automatic logic [AW-1:0] byte_addr(input logic [8:0] ln, input logic [8:0] cl);
    return AW'(ln) * AW'(BPL) + AW'(cl);
  endfunction

  // Line/column math is kept at 9 bits so the edge tests see the true coordinate.
  always_comb begin
    line9    = {1'b0, y_q} + {4'b0, r_q};
    line_w   = WRAP ? (line9 % 9'(DISP_H)) : line9;
    col0     = {4'b0, x_q[7:3]};
    col1_raw = col0 + 9'd1;
    col1     = (WRAP && (col1_raw == 9'(BPL))) ? 9'd0 : col1_raw;
    has_b1   = (x_q[2:0] != 3'd0) && (WRAP || (col1_raw < 9'(BPL)));
    shifted  = {spr_q, 8'h00} >> x_q[2:0];
    mask0    = shifted[15:8];
    mask1    = shifted[7:0];
    r_nx     = r_q + 5'd1;
    line_nx  = {1'b0, y_q} + {4'b0, r_nx};
    last_row = (r_nx == rows_q) || (!WRAP && (line_nx >= 9'(DISP_H)));
    rows_sat = (rows > MAXR) ? MAXR : rows;
  end

  always_comb begin
    state_d     = state_q;
    base_d      = base_q;
    x_d         = x_q;
    y_d         = y_q;
    rows_d      = rows_q;
    r_d         = r_q;
    spr_d       = spr_q;
    wr_dat_d    = wr_dat_q;
    mem_addr_d  = mem_addr_q;
    vram_addr_d = vram_addr_q;
    we_d        = 1'b0;
    coll_d      = coll_q;
    adv         = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        base_d = sprite_addr;
        x_d    = 8'({1'b0, x} % 9'(DISP_W));
        y_d    = 8'({1'b0, y} % 9'(DISP_H));
        rows_d = rows_sat;
        r_d    = 5'd0;
        coll_d = 1'b0;
        if (rows_sat == 5'd0) begin
          state_d = DONE;
        end else begin
          mem_addr_d = sprite_addr;
          state_d    = FETCH;
        end
      end
      FETCH, NEXT: state_d = FETCH_WAIT;
      FETCH_WAIT: begin
        spr_d       = mem_rd_data;
        vram_addr_d = byte_addr(line_w, col0);
        state_d     = RD0;
      end
      RD0: state_d = RD0_WAIT;
      RD0_WAIT: begin
        wr_dat_d = vram_rd_data ^ mask0;
        coll_d   = coll_q | (|(vram_rd_data & mask0));
        we_d     = 1'b1;
        state_d  = WR0;
      end
      WR0: begin
        if (has_b1) begin
          vram_addr_d = byte_addr(line_w, col1);
          state_d     = RD1;
        end else begin
          adv = 1'b1;
        end
      end
      RD1: state_d = RD1_WAIT;
      RD1_WAIT: begin
        wr_dat_d = vram_rd_data ^ mask1;
        coll_d   = coll_q | (|(vram_rd_data & mask1));
        we_d     = 1'b1;
        state_d  = WR1;
      end
      WR1:  adv = 1'b1;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // NEXT issues the following row's fetch, so row turnaround costs no extra cycle.
    if (adv) begin
      r_d = r_nx;
      if (last_row) begin
        state_d = DONE;
      end else begin
        mem_addr_d = base_q + {7'b0, r_nx};
        state_d    = NEXT;
      end
    end
  end

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      base_q      <= '0;
      x_q         <= '0;
      y_q         <= '0;
      rows_q      <= '0;
      r_q         <= '0;
      spr_q       <= '0;
      wr_dat_q    <= '0;
      mem_addr_q  <= '0;
      vram_addr_q <= '0;
      we_q        <= 1'b0;
      coll_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      x_q         <= x_d;
      y_q         <= y_d;
      rows_q      <= rows_d;
      r_q         <= r_d;
      spr_q       <= spr_d;
      wr_dat_q    <= wr_dat_d;
      mem_addr_q  <= mem_addr_d;
      vram_addr_q <= vram_addr_d;
      we_q        <= we_d;
      coll_q      <= coll_d;
    end
  end

  assign mem_rd_addr  = mem_addr_q;
  assign vram_addr    = vram_addr_q;
  assign vram_wr_data = wr_dat_q;
  assign vram_we      = we_q;
  assign busy         = (state_q != IDLE);
  assign done         = (state_q == DONE);
  assign collision    = coll_q;

endmodule

// File: tb/tb_sprite_blitter.sv
// Directed bench for sprite_blitter with behavioural sprite memory and 64x32 framebuffer.
module tb_sprite_blitter;
  logic        clk_in = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [11:0] sprite_addr = '0;
  logic [7:0]  x = '0, y = '0;
  logic [4:0]  rows = '0;
  logic [11:0] mem_rd_addr;
  logic [7:0]  mem_rd_data;
  logic [7:0]  vram_addr;
  logic [7:0]  vram_rd_data, vram_wr_data;
  logic        vram_we, busy, done, collision;

  int   checks = 0;
  int   failures = 0;
  int   we_cnt = 0;
  logic fb_clr = 1'b0;
  logic [7:0] smem [4096];
  logic [7:0] fb [256];

  sprite_blitter dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .sprite_addr(sprite_addr),
    .x(x), .y(y), .rows(rows), .mem_rd_addr(mem_rd_addr), .mem_rd_data(mem_rd_data),
    .vram_addr(vram_addr), .vram_rd_data(vram_rd_data), .vram_wr_data(vram_wr_data),
    .vram_we(vram_we), .busy(busy), .done(done), .collision(collision)
  );

  always #5 clk_in = ~clk_in;

  always @(posedge clk_in) begin
    mem_rd_data  <= smem[mem_rd_addr];
    vram_rd_data <= fb[vram_addr];
    if (fb_clr) begin
      for (int i = 0; i < 256; i++) fb[i] <= 8'h00;
    end else if (vram_we) begin
      fb[vram_addr] <= vram_wr_data;
      we_cnt        <= we_cnt + 1;
    end
  end

  task automatic clear_fb();
    @(posedge clk_in); #1;
    fb_clr = 1'b1;
    @(posedge clk_in); #1;
    fb_clr = 1'b0;
  endtask

  // cyc is the cycle index in which done is seen; the start-sampling cycle is cycle 0.
  task automatic run_draw(input logic [11:0] a, input logic [7:0] xx, input logic [7:0] yy,
                          input logic [4:0] rr, input bit poke, output int cyc);
    @(posedge clk_in); #1;
    sprite_addr = a; x = xx; y = yy; rows = rr; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    cyc = 1;
    while (!done && cyc < 200) begin
      if (poke && cyc == 3) begin
        sprite_addr = 12'h000; x = 8'd0; y = 8'd0; rows = 5'd1; start = 1'b1;
      end else begin
        start = 1'b0;
      end
      @(posedge clk_in); #1;
      cyc++;
    end
  endtask

  task automatic test_reset();
    #2;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin failures++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL reset_we got=%b exp=0", vram_we); end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL reset_coll got=%b exp=0", collision); end
    checks++; if (mem_rd_addr !== 12'h000) begin failures++; $display("FAIL reset_maddr got=%h exp=000", mem_rd_addr); end
    checks++; if (vram_addr !== 8'h00) begin failures++; $display("FAIL reset_vaddr got=%h exp=00", vram_addr); end
    @(posedge clk_in); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_basic();
    int cyc, w0;
    clear_fb();
    smem[12'h300] = 8'hF0;
    w0 = we_cnt;
    run_draw(12'h300, 8'd0, 8'd0, 5'd1, 1'b0, cyc);
    checks++; if (cyc != 6) begin failures++; $display("FAIL basic_latency got=%0d exp=6", cyc); end
    checks++; if (fb[0] !== 8'hF0) begin failures++; $display("FAIL basic_byte0 got=%h exp=f0", fb[0]); end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL basic_coll got=%b exp=0", collision); end
    checks++; if (we_cnt - w0 != 1) begin failures++; $display("FAIL basic_writes got=%0d exp=1", we_cnt - w0); end
    @(posedge clk_in); #1;
    checks++; if (done !== 1'b0 || busy !== 1'b0) begin
      failures++; $display("FAIL basic_idle done=%b busy=%b exp=0/0", done, busy);
    end
  endtask

  task automatic test_collision();
    int cyc;
    run_draw(12'h300, 8'd0, 8'd0, 5'd1, 1'b0, cyc);
    checks++; if (fb[0] !== 8'h00) begin failures++; $display("FAIL coll_byte0 got=%h exp=00", fb[0]); end
    checks++; if (collision !== 1'b1) begin failures++; $display("FAIL coll_flag got=%b exp=1", collision); end
    repeat (3) @(posedge clk_in);
    #1;
    checks++; if (collision !== 1'b1) begin failures++; $display("FAIL coll_held got=%b exp=1", collision); end
  endtask

  task automatic test_rows_zero();
    int cyc, w0;
    w0 = we_cnt;
    run_draw(12'h123, 8'd5, 8'd5, 5'd0, 1'b0, cyc);
    checks++; if (cyc != 1) begin failures++; $display("FAIL rows0_latency got=%0d exp=1", cyc); end
    checks++; if (we_cnt - w0 != 0) begin failures++; $display("FAIL rows0_writes got=%0d exp=0", we_cnt - w0); end
    checks++; if (mem_rd_addr !== 12'h300) begin failures++; $display("FAIL rows0_maddr got=%h exp=300", mem_rd_addr); end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL rows0_coll got=%b exp=0", collision); end
  endtask

  task automatic test_straddle();
    int cyc, w0;
    clear_fb();
    smem[12'h310] = 8'hFF;
    w0 = we_cnt;
    run_draw(12'h310, 8'd4, 8'd1, 5'd1, 1'b0, cyc);
    checks++; if (cyc != 9) begin failures++; $display("FAIL strad_latency got=%0d exp=9", cyc); end
    checks++; if (fb[8] !== 8'h0F) begin failures++; $display("FAIL strad_byte8 got=%h exp=0f", fb[8]); end
    checks++; if (fb[9] !== 8'hF0) begin failures++; $display("FAIL strad_byte9 got=%h exp=f0", fb[9]); end
    checks++; if (we_cnt - w0 != 2) begin failures++; $display("FAIL strad_writes got=%0d exp=2", we_cnt - w0); end
    checks++; if (collision !== 1'b0) begin failures++; $display("FAIL strad_coll got=%b exp=0", collision); end
  endtask

  // x=72,y=34 reduce to 8,2; source address wraps 0xFFE..0x000; a start mid-draw must be ignored.
  task automatic test_multi();
    int cyc, w0;
    clear_fb();
    smem[12'hFFE] = 8'hA5; smem[12'hFFF] = 8'h3C; smem[12'h000] = 8'h81;
    w0 = we_cnt;
    run_draw(12'hFFE, 8'd72, 8'd34, 5'd3, 1'b1, cyc);
    checks++; if (cyc != 16) begin failures++; $display("FAIL multi_latency got=%0d exp=16", cyc); end
    checks++; if (fb[17] !== 8'hA5) begin failures++; $display("FAIL multi_byte17 got=%h exp=a5", fb[17]); end
    checks++; if (fb[25] !== 8'h3C) begin failures++; $display("FAIL multi_byte25 got=%h exp=3c", fb[25]); end
    checks++; if (fb[33] !== 8'h81) begin failures++; $display("FAIL multi_byte33 got=%h exp=81", fb[33]); end
    checks++; if (fb[0] !== 8'h00) begin failures++; $display("FAIL multi_byte0 got=%h exp=00", fb[0]); end
    checks++; if (we_cnt - w0 != 3) begin failures++; $display("FAIL multi_writes got=%0d exp=3", we_cnt - w0); end
  endtask

  task automatic test_edge();
    int cyc;
    clear_fb();
    smem[12'h320] = 8'hFF; smem[12'h321] = 8'hFF;
    run_draw(12'h320, 8'd60, 8'd31, 5'd2, 1'b0, cyc);
    checks++; if (fb[255] !== 8'h0F) begin failures++; $display("FAIL edge_byte255 got=%h exp=0f", fb[255]); end
`ifdef BLIT_WRAP_EN
    checks++; if (cyc != 17) begin failures++; $display("FAIL edge_latency got=%0d exp=17", cyc); end
    checks++; if (fb[248] !== 8'hF0) begin failures++; $display("FAIL edge_byte248 got=%h exp=f0", fb[248]); end
    checks++; if (fb[7] !== 8'h0F) begin failures++; $display("FAIL edge_byte7 got=%h exp=0f", fb[7]); end
    checks++; if (fb[0] !== 8'hF0) begin failures++; $display("FAIL edge_byte0 got=%h exp=f0", fb[0]); end
`else
    checks++; if (cyc != 6) begin failures++; $display("FAIL edge_latency got=%0d exp=6", cyc); end
    checks++; if (fb[248] !== 8'h00) begin failures++; $display("FAIL edge_byte248 got=%h exp=00", fb[248]); end
    checks++; if (fb[7] !== 8'h00) begin failures++; $display("FAIL edge_byte7 got=%h exp=00", fb[7]); end
    checks++; if (fb[0] !== 8'h00) begin failures++; $display("FAIL edge_byte0 got=%h exp=00", fb[0]); end
`endif
  endtask

  task automatic test_reset_mid();
    int cyc, w0;
    bit seen_done;
    clear_fb();
    for (int i = 0; i < 4; i++) smem[12'h330 + i] = 8'hFF;
    w0 = we_cnt;
    @(posedge clk_in); #1;
    sprite_addr = 12'h330; x = 8'd0; y = 8'd10; rows = 5'd4; start = 1'b1;
    @(posedge clk_in); #1;
    start = 1'b0;
    repeat (2) @(posedge clk_in);
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy got=%b exp=0", busy); end
    checks++; if (vram_we !== 1'b0) begin failures++; $display("FAIL rstmid_we got=%b exp=0", vram_we); end
    checks++; if (vram_addr !== 8'h00) begin failures++; $display("FAIL rstmid_vaddr got=%h exp=00", vram_addr); end
    checks++; if (mem_rd_addr !== 12'h000) begin failures++; $display("FAIL rstmid_maddr got=%h exp=000", mem_rd_addr); end
    seen_done = 1'b0;
    repeat (5) begin
      @(posedge clk_in); #1;
      if (done) seen_done = 1'b1;
    end
    checks++; if (seen_done) begin failures++; $display("FAIL rstmid_nodone got=1 exp=0"); end
    checks++; if (we_cnt - w0 != 0) begin failures++; $display("FAIL rstmid_writes got=%0d exp=0", we_cnt - w0); end
    rst_n = 1'b1;
    run_draw(12'h330, 8'd0, 8'd10, 5'd1, 1'b0, cyc);
    checks++; if (cyc != 6) begin failures++; $display("FAIL rstmid_redraw_lat got=%0d exp=6", cyc); end
    checks++; if (fb[80] !== 8'hFF) begin failures++; $display("FAIL rstmid_byte80 got=%h exp=ff", fb[80]); end
    checks++; if (fb[88] !== 8'h00) begin failures++; $display("FAIL rstmid_byte88 got=%h exp=00", fb[88]); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_collision();
    test_rows_zero();
    test_straddle();
    test_multi();
    test_edge();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/sprite_blitter.md
SPRITE_BLITTER -- requirements
Module: sprite_blitter

Interface
REQ-001 Parameter DISP_W, 64, display width in logical pixels; multiple of 8, 8..256.
REQ-002 Parameter DISP_H, 32, display height in logical pixels, 1..256.
REQ-003 Parameter MAX_ROWS, 16, largest accepted sprite height; rows above it are saturated to MAX_ROWS.
REQ-004 Port clk_in  in  1  sole clock; all logic on its rising edge.
REQ-005 Port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-006 Port start  in  1  draw request, sampled only in IDLE.
REQ-007 Port sprite_addr  in  12  main-memory address of sprite row 0.
REQ-008 Port x / y  in  8 each  sprite origin, reduced mod DISP_W / DISP_H at start.
REQ-009 Port rows  in  5  sprite height in bytes (0 = empty draw).
REQ-010 Port mem_rd_addr / mem_rd_data  out 12 / in 8  sprite memory read; data valid one cycle after address.
REQ-011 Port vram_addr  out  $clog2(DISP_W*DISP_H/8)  framebuffer byte address, row-major, DISP_W/8 bytes per line, pixel bit 7 = leftmost.
REQ-012 Port vram_rd_data / vram_wr_data / vram_we  in 8 / out 8 / out 1  framebuffer read (1-cycle latency) and write.
REQ-013 Port busy, done, collision  out 1 each  engine active; one-cycle completion pulse; any lit pixel turned off.

Function
REQ-014 FSM states: IDLE, FETCH, FETCH_WAIT, RD0, RD0_WAIT, WR0, RD1, RD1_WAIT, WR1, NEXT, DONE.
REQ-015 IDLE with start=1 latches all inputs, clears collision, enters FETCH (or DONE if rows=0); busy=1 from next cycle.
REQ-016 start while busy is ignored; latched inputs are not affected by later input changes.
REQ-017 Each sprite row: FETCH drives mem_rd_addr=sprite_addr+r (12-bit wrap); sprite byte captured in FETCH_WAIT.
REQ-018 Byte 0 = line (y+r), column x/8; sprite byte shifted right by x%8; WR0 writes old XOR shifted bits.
REQ-019 If x%8!=0, byte 1 = next column, receives the low x%8 sprite bits in its top bits, via RD1/RD1_WAIT/WR1.
REQ-020 collision |= (old & mask) on every WR; never cleared mid-draw.
REQ-021 Latency: aligned row 5 cycles, straddling row 8; done in the cycle after last write, i.e. 1+5A+8U cycles after start edge.
REQ-022 vram_we high only in WR0/WR1, exactly one cycle each; mem and vram addresses hold value otherwise.
REQ-023 DONE pulses done=1, drops busy, returns to IDLE; collision held until next accepted start.
REQ-024 Line (y+r) and column indices computed at 9 bits, no truncation before the edge test.

Reset
REQ-025 rst_n low: immediately state=IDLE, busy=0, done=0, vram_we=0, collision=0, all addresses 0.
REQ-026 Reset mid-draw abandons the draw; already-written bytes are not restored; no done pulse.

Configuration
REQ-027 Macro BLIT_WRAP_EN defined: columns past DISP_W-1 wrap to column 0 of same line; lines past DISP_H-1 wrap to line 0.
REQ-028 BLIT_WRAP_EN undefined: bits past right edge masked (byte 1 skipped when column = DISP_W/8), draw ends at first row with line >= DISP_H; latency counts only executed rows/bytes.

Verification
REQ-029 Cleared fb, sprite 0xF0 at 0x300, x=0,y=0,rows=1 -> byte0=0xF0, collision=0, done 6 cycles after start.
REQ-030 Repeat same draw -> byte0=0x00, collision=1.
REQ-031 Sprite 0xFF, x=4,y=1,rows=1 -> byte8=0x0F, byte9=0xF0, done 9 cycles after start.
REQ-032 Sprite 0xFF, x=60,y=31,rows=2: with BLIT_WRAP_EN bytes 255=0x0F,248=0xF0,7=0x0F,0=0xF0; without, only byte255=0x0F.
REQ-033 rst_n low at cycle 3 of a rows=4 draw -> busy=0, vram_we=0 at once, no done; next start completes normally.
REQ-034 rows=0 -> no memory or vram access, done one cycle after start, collision=0.
